param_stream_sorter: RTL and testbench

- Parametrised successor to the single-port bubble sorter: buffers up to DEPTH {key, tag} records and sorts them by key with an odd-even transposition network.
- Sort order is ascending or descending, and keys are compared as signed or unsigned.
- Records load and drain through valid/ready streams, so the block sits between a producer stream and a backpressured consumer.
- A full pass completes in exactly count cycles, independent of the data.

---
 rtl/param_stream_sorter_if.sv | 39 +++
 rtl/param_stream_sorter.sv | 199 +++++++++++++++++++
 tb/tb_param_stream_sorter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/param_stream_sorter_if.sv
// Stream and control bundle for param_stream_sorter.
//   in_valid/in_ready/in_key/in_tag     : producer stream of {key, tag} records
//   start/descending/clear               : sort control, sampled while loading
//   out_valid/out_ready/out_key/out_tag/out_last : sorted consumer stream
//   count/busy/overflow                  : buffer occupancy and status
// The master modport is the environment side; the sorter takes the slave modport.
interface param_stream_sorter_if #(
   parameter int unsigned KEY_WIDTH = 32,
   parameter int unsigned TAG_WIDTH = 8,
   parameter int unsigned DEPTH     = 16
) ();
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic                 in_valid;
   logic                 in_ready;
   logic [KEY_WIDTH-1:0] in_key;
   logic [TAG_WIDTH-1:0] in_tag;
   logic                 start;
   logic                 descending;
   logic                 clear;
   logic                 out_valid;
   logic                 out_ready;
   logic [KEY_WIDTH-1:0] out_key;
   logic [TAG_WIDTH-1:0] out_tag;
   logic                 out_last;
   logic [CW-1:0]        count;
   logic                 busy;
   logic                 overflow;

   modport master (
      output in_valid, in_key, in_tag, start, descending, clear, out_ready,
      input  in_ready, out_valid, out_key, out_tag, out_last, count, busy, overflow
   );

   modport slave (
      input  in_valid, in_key, in_tag, start, descending, clear, out_ready,
      output in_ready, out_valid, out_key, out_tag, out_last, count, busy, overflow
   );
endinterface

// File: rtl/param_stream_sorter.sv
// Buffers up to DEPTH {key, tag} records, sorts them by key with an odd-even
// transposition network (one pass per cycle, count passes in total) and drains
// them through a registered valid/ready stream.
// Ports:
//   clk   : clock
//   reset : synchronous, active-high reset
//   bus   : param_stream_sorter_if.slave (load stream, control, drain stream, status)
module param_stream_sorter #(
   parameter int unsigned KEY_WIDTH   = 32,
   parameter int unsigned TAG_WIDTH   = 8,
   parameter int unsigned DEPTH       = 16,
   parameter bit          SIGNED_KEYS = 1'b0
) (
   input logic                  clk,
   input logic                  reset,
   param_stream_sorter_if.slave bus
);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned IW = $clog2(DEPTH);

   typedef enum logic [1:0] {StLoad, StSort, StDrain} state_e;

   state_e               r_state;
   state_e               w_state_d;

   logic [KEY_WIDTH-1:0] r_keys [DEPTH];
   logic [TAG_WIDTH-1:0] r_tags [DEPTH];
   logic [KEY_WIDTH-1:0] w_keys_sorted [DEPTH];
   logic [TAG_WIDTH-1:0] w_tags_sorted [DEPTH];

   logic [CW-1:0]        r_count;
   logic [CW-1:0]        r_pass;
   logic [IW-1:0]        r_idx;
   logic                 r_order;
   logic                 r_overflow;
   logic                 r_out_valid;
   logic                 r_out_last;
   logic [KEY_WIDTH-1:0] r_out_key;
   logic [TAG_WIDTH-1:0] r_out_tag;

   logic                 w_in_ready;
   logic                 w_push;
   logic                 w_drop;
   logic                 w_start;
   logic [CW-1:0]        w_n;
   logic                 w_load_out;
   logic                 w_advance;
   logic                 w_done;
   logic [IW-1:0]        w_next_idx;

   function automatic logic key_gt(input logic [KEY_WIDTH-1:0] a,
                                   input logic [KEY_WIDTH-1:0] b);
      if (SIGNED_KEYS) begin
         return $signed(a) > $signed(b);
      end
      return a > b;
   endfunction

   // Next state and handshake decode.
   always_comb begin
      w_state_d  = r_state;
      w_in_ready = 1'b0;
      w_push     = 1'b0;
      w_drop     = 1'b0;
      w_start    = 1'b0;
      w_n        = r_count;
      w_load_out = 1'b0;
      w_advance  = 1'b0;
      w_done     = 1'b0;
      unique case (r_state)
         StLoad: begin
            w_in_ready = (r_count < CW'(DEPTH));
            w_push     = bus.in_valid && w_in_ready && !bus.clear;
            w_drop     = bus.in_valid && !w_in_ready && !bus.clear;
            // A push in the start cycle is part of the sort.
            w_n        = r_count + CW'(w_push);
            w_start    = bus.start && !bus.clear && (w_n != '0);
            if (w_start) begin
               w_state_d = (w_n == CW'(1)) ? StDrain : StSort;
            end
         end
         StSort: begin
            if (r_pass == r_count - CW'(1)) begin
               w_state_d = StDrain;
            end
         end
         StDrain: begin
            // First DRAIN cycle fills the output register; then one record per handshake.
            w_load_out = !r_out_valid;
            w_advance  = r_out_valid && bus.out_ready && !r_out_last;
            w_done     = r_out_valid && bus.out_ready && r_out_last;
            if (w_done) begin
               w_state_d = StLoad;
            end
         end
         default: w_state_d = StLoad;
      endcase
   end

   // One transposition pass: pairs (i, i+1) with i matching the pass parity.
   always_comb begin
      w_keys_sorted = r_keys;
      w_tags_sorted = r_tags;
      for (int i = 0; i < int'(DEPTH) - 1; i++) begin
         if ((i[0] == r_pass[0]) && ((i + 1) < int'(r_count))) begin
            // Strict compare: equal keys stay put, keeping the sort stable.
            if (r_order ? key_gt(r_keys[i+1], r_keys[i]) : key_gt(r_keys[i], r_keys[i+1])) begin
               w_keys_sorted[i]   = r_keys[i+1];
               w_keys_sorted[i+1] = r_keys[i];
               w_tags_sorted[i]   = r_tags[i+1];
               w_tags_sorted[i+1] = r_tags[i];
            end
         end
      end
   end

   assign w_next_idx = r_idx + IW'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= StLoad;
      end else begin
         r_state <= w_state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_keys[i] <= '0;
            r_tags[i] <= '0;
         end
         r_count     <= '0;
         r_pass      <= '0;
         r_idx       <= '0;
         r_order     <= 1'b0;
         r_overflow  <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_key   <= '0;
         r_out_tag   <= '0;
      end else begin
         unique case (r_state)
            StLoad: begin
               r_pass <= '0;
               r_idx  <= '0;
               if (bus.clear) begin
                  r_count    <= '0;
                  r_overflow <= 1'b0;
               end else begin
                  if (w_push) begin
                     r_keys[IW'(r_count)] <= bus.in_key;
                     r_tags[IW'(r_count)] <= bus.in_tag;
                  end
                  if (w_drop) begin
                     r_overflow <= 1'b1;
                  end
                  if (w_start) begin
                     r_order <= bus.descending;
                  end
                  r_count <= w_n;
               end
            end
            StSort: begin
               r_keys <= w_keys_sorted;
               r_tags <= w_tags_sorted;
               r_pass <= r_pass + CW'(1);
            end
            StDrain: begin
               if (w_load_out) begin
                  r_out_valid <= 1'b1;
                  r_out_key   <= r_keys[r_idx];
                  r_out_tag   <= r_tags[r_idx];
                  r_out_last  <= (CW'(r_idx) == r_count - CW'(1));
               end else if (w_advance) begin
                  r_idx      <= w_next_idx;
                  r_out_key  <= r_keys[w_next_idx];
                  r_out_tag  <= r_tags[w_next_idx];
                  r_out_last <= (CW'(w_next_idx) == r_count - CW'(1));
               end else if (w_done) begin
                  r_out_valid <= 1'b0;
                  r_out_last  <= 1'b0;
                  r_count     <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = w_in_ready && !reset;
   assign bus.out_valid = r_out_valid;
   assign bus.out_key   = r_out_key;
   assign bus.out_tag   = r_out_tag;
   assign bus.out_last  = r_out_last;
   assign bus.count     = r_count;
   assign bus.busy      = (r_state != StLoad);
   assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_param_stream_sorter.sv
// Bench for param_stream_sorter: an unsigned and a signed instance share the
// stimulus, sel picks which one receives in_valid/start and is observed.
module tb_param_stream_sorter;
   localparam int unsigned KW = 8;
   localparam int unsigned TW = 8;
   localparam int unsigned DP = 8;
   localparam int unsigned CW = $clog2(DP + 1);

   typedef struct packed {
      logic [KW-1:0] key;
      logic [TW-1:0] tag;
   } rec_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic sel = 1'b0;
   logic in_valid = 1'b0;
   logic [KW-1:0] in_key = '0;
   logic [TW-1:0] in_tag = '0;
   logic start = 1'b0;
   logic descending = 1'b0;
   logic clear = 1'b0;
   logic out_ready = 1'b0;

   logic          o_in_ready, o_out_valid, o_out_last, o_busy, o_overflow;
   logic [KW-1:0] o_out_key;
   logic [TW-1:0] o_out_tag;
   logic [CW-1:0] o_count;

   int n_checks = 0;
   int n_fail = 0;
   rec_t m_q[$];
   rec_t m_exp[$];

   always #5 clk = ~clk;

   param_stream_sorter_if #(.KEY_WIDTH(KW), .TAG_WIDTH(TW), .DEPTH(DP)) bus_u ();
   param_stream_sorter_if #(.KEY_WIDTH(KW), .TAG_WIDTH(TW), .DEPTH(DP)) bus_s ();

   param_stream_sorter #(.KEY_WIDTH(KW), .TAG_WIDTH(TW), .DEPTH(DP), .SIGNED_KEYS(1'b0)) dut_u (
      .clk(clk), .reset(reset), .bus(bus_u));
   param_stream_sorter #(.KEY_WIDTH(KW), .TAG_WIDTH(TW), .DEPTH(DP), .SIGNED_KEYS(1'b1)) dut_s (
      .clk(clk), .reset(reset), .bus(bus_s));

   assign bus_u.in_valid   = in_valid & ~sel;
   assign bus_s.in_valid   = in_valid & sel;
   assign bus_u.start      = start & ~sel;
   assign bus_s.start      = start & sel;
   assign bus_u.in_key     = in_key;
   assign bus_s.in_key     = in_key;
   assign bus_u.in_tag     = in_tag;
   assign bus_s.in_tag     = in_tag;
   assign bus_u.descending = descending;
   assign bus_s.descending = descending;
   assign bus_u.clear      = clear;
   assign bus_s.clear      = clear;
   assign bus_u.out_ready  = out_ready;
   assign bus_s.out_ready  = out_ready;

   assign o_in_ready  = sel ? bus_s.in_ready  : bus_u.in_ready;
   assign o_out_valid = sel ? bus_s.out_valid : bus_u.out_valid;
   assign o_out_key   = sel ? bus_s.out_key   : bus_u.out_key;
   assign o_out_tag   = sel ? bus_s.out_tag   : bus_u.out_tag;
   assign o_out_last  = sel ? bus_s.out_last  : bus_u.out_last;
   assign o_count     = sel ? bus_s.count     : bus_u.count;
   assign o_busy      = sel ? bus_s.busy      : bus_u.busy;
   assign o_overflow  = sel ? bus_s.overflow  : bus_u.overflow;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Record a goes strictly before b in the requested order.
   function automatic bit goes_before(input rec_t a, input rec_t b, input bit desc, input bit sgn);
      int ka, kb;
      if (sgn) begin
         ka = $signed(a.key);
         kb = $signed(b.key);
      end else begin
         ka = int'(a.key);
         kb = int'(b.key);
      end
      return desc ? (ka > kb) : (ka < kb);
   endfunction

   // Stable insertion sort of the loaded records.
   task automatic build_expected(input bit desc, input bit sgn);
      int pos;
      m_exp.delete();
      foreach (m_q[a]) begin
         pos = m_exp.size();
         for (int j = 0; j < m_exp.size(); j++) begin
            if (goes_before(m_q[a], m_exp[j], desc, sgn)) begin
               pos = j;
               break;
            end
         end
         m_exp.insert(pos, m_q[a]);
      end
   endtask

   task automatic push(input logic [KW-1:0] k, input logic [TW-1:0] t);
      in_valid = 1'b1;
      in_key = k;
      in_tag = t;
      if (o_in_ready) m_q.push_back('{key: k, tag: t});
      tick();
      in_valid = 1'b0;
   endtask

   // Start a sort (optionally with a same-cycle push), check latency and the drained stream.
   task automatic run_sort(input bit desc, input bit with_push, input logic [KW-1:0] pk,
                           input logic [TW-1:0] pt, input bit rand_ready, input string name);
      int n, lat, exp_lat, k, cyc;
      bit stalled, hs;
      rec_t prev;
      bit prev_last;
      start = 1'b1;
      descending = desc;
      out_ready = 1'b0;
      if (with_push) begin
         in_valid = 1'b1;
         in_key = pk;
         in_tag = pt;
         m_q.push_back('{key: pk, tag: pt});
      end
      tick();
      start = 1'b0;
      in_valid = 1'b0;
      n = m_q.size();
      build_expected(desc, sel);
      exp_lat = (n == 1) ? 1 : n + 1;
      lat = 0;
      while (!o_out_valid && lat < 100) begin
         tick();
         lat++;
      end
      n_checks++;
      if (lat !== exp_lat) $display("FAIL %s latency: got %0d cycles, expected %0d", name, lat, exp_lat);
      if (lat !== exp_lat) n_fail++;
      k = 0;
      cyc = 0;
      stalled = 1'b0;
      prev = '0;
      prev_last = 1'b0;
      while (k < n && cyc < 500) begin
         if (o_out_valid) begin
            if (stalled) begin
               n_checks++;
               if ({o_out_key, o_out_tag, o_out_last} !== {prev.key, prev.tag, prev_last}) begin
                  n_fail++;
                  $display("FAIL %s hold: got %0h/%0h/%0b, expected %0h/%0h/%0b", name, o_out_key,
                           o_out_tag, o_out_last, prev.key, prev.tag, prev_last);
               end
            end
            n_checks++;
            if ({o_out_key, o_out_tag, o_out_last} !== {m_exp[k].key, m_exp[k].tag, k == n - 1}) begin
               n_fail++;
               $display("FAIL %s record %0d: got key=%0h tag=%0h last=%0b, expected key=%0h tag=%0h last=%0b",
                        name, k, o_out_key, o_out_tag, o_out_last, m_exp[k].key, m_exp[k].tag, k == n - 1);
            end
         end
         out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         stalled = o_out_valid && !out_ready;
         hs = o_out_valid && out_ready;
         prev = '{key: o_out_key, tag: o_out_tag};
         prev_last = o_out_last;
         tick();
         cyc++;
         if (hs) k++;
      end
      out_ready = 1'b0;
      n_checks++;
      if (k != n) begin
         n_fail++;
         $display("FAIL %s drain: got %0d records, expected %0d", name, k, n);
      end
      n_checks++;
      if ({o_out_valid, o_busy, o_count} !== {1'b0, 1'b0, CW'(0)}) begin
         n_fail++;
         $display("FAIL %s after drain: got valid=%0b busy=%0b count=%0d, expected 0/0/0", name,
                  o_out_valid, o_busy, o_count);
      end
      m_q.delete();
   endtask

   task automatic test_reset();
      sel = 1'b0;
      reset = 1'b1;
      tick();
      tick();
      n_checks++;
      if (o_in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset in_ready: got %0b, expected 0", o_in_ready);
      end
      n_checks++;
      if ({o_out_valid, o_out_last, o_busy, o_overflow, o_count, o_out_key, o_out_tag} !== '0) begin
         n_fail++;
         $display("FAIL reset outputs: got v=%0b l=%0b b=%0b o=%0b c=%0d k=%0h t=%0h, expected all 0",
                  o_out_valid, o_out_last, o_busy, o_overflow, o_count, o_out_key, o_out_tag);
      end
      reset = 1'b0;
      tick();
      n_checks++;
      if (o_in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL post-reset in_ready: got %0b, expected 1", o_in_ready);
      end
      m_q.delete();
   endtask

   task automatic test_basic();
      sel = 1'b0;
      push(8'd5, 8'd0);
      push(8'd3, 8'd1);
      push(8'd9, 8'd2);
      push(8'd1, 8'd3);
      n_checks++;
      if (o_count !== CW'(4)) begin
         n_fail++;
         $display("FAIL basic count: got %0d, expected 4", o_count);
      end
      run_sort(1'b0, 1'b0, '0, '0, 1'b0, "basic");
   endtask

   task automatic test_signed();
      for (int s = 1; s >= 0; s--) begin
         sel = 1'(s);
         push(8'hFF, 8'd0);
         push(8'h02, 8'd1);
         push(8'h80, 8'd2);
         run_sort(1'b1, 1'b0, '0, '0, 1'b0, s == 1 ? "signed_desc" : "unsigned_desc");
      end
      sel = 1'b0;
   endtask

   task automatic test_stability();
      sel = 1'b0;
      push(8'd7, 8'hA);
      push(8'd7, 8'hB);
      push(8'd7, 8'hC);
      push(8'd1, 8'hD);
      run_sort(1'b0, 1'b0, '0, '0, 1'b1, "stability");
   endtask

   task automatic test_overflow();
      sel = 1'b0;
      for (int i = 0; i < int'(DP); i++) push(8'($urandom), 8'(i));
      n_checks++;
      if ({o_count, o_in_ready} !== {CW'(DP), 1'b0}) begin
         n_fail++;
         $display("FAIL full: got count=%0d in_ready=%0b, expected %0d/0", o_count, o_in_ready, DP);
      end
      push(8'h55, 8'h55);
      n_checks++;
      if ({o_count, o_overflow} !== {CW'(DP), 1'b1}) begin
         n_fail++;
         $display("FAIL overflow: got count=%0d overflow=%0b, expected %0d/1", o_count, o_overflow, DP);
      end
      clear = 1'b1;
      tick();
      clear = 1'b0;
      m_q.delete();
      n_checks++;
      if ({o_count, o_overflow} !== {CW'(0), 1'b0}) begin
         n_fail++;
         $display("FAIL clear: got count=%0d overflow=%0b, expected 0/0", o_count, o_overflow);
      end
      in_valid = 1'b1;
      in_key = 8'h33;
      clear = 1'b1;
      tick();
      in_valid = 1'b0;
      clear = 1'b0;
      n_checks++;
      if (o_count !== CW'(0)) begin
         n_fail++;
         $display("FAIL push with clear: got count=%0d, expected 0", o_count);
      end
      push(8'd4, 8'd0);
      push(8'd2, 8'd1);
      clear = 1'b1;
      start = 1'b1;
      tick();
      clear = 1'b0;
      start = 1'b0;
      m_q.delete();
      n_checks++;
      if ({o_busy, o_count} !== {1'b0, CW'(0)}) begin
         n_fail++;
         $display("FAIL start with clear: got busy=%0b count=%0d, expected 0/0", o_busy, o_count);
      end
   endtask

   task automatic test_small_counts();
      sel = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      n_checks++;
      if (o_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL empty start: got busy=%0b, expected 0", o_busy);
      end
      push(8'd42, 8'd7);
      run_sort(1'b0, 1'b0, '0, '0, 1'b0, "single");
      push(8'd20, 8'd0);
      push(8'd10, 8'd1);
      run_sort(1'b0, 1'b1, 8'd15, 8'd2, 1'b0, "push_with_start");
   endtask

   task automatic test_random();
      int n;
      bit wp;
      for (int it = 0; it < 12; it++) begin
         sel = 1'($urandom_range(0, 1));
         n = $urandom_range(1, DP);
         wp = 1'($urandom_range(0, 1));
         for (int i = 0; i < n - int'(wp); i++) begin
            push((it % 2 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom), 8'(i));
         end
         n_checks++;
         if (o_count !== CW'(m_q.size())) begin
            n_fail++;
            $display("FAIL random%0d count: got %0d, expected %0d", it, o_count, m_q.size());
         end
         run_sort(1'($urandom_range(0, 1)), wp, 8'($urandom), 8'(n - 1), 1'b1, "random");
      end
      sel = 1'b0;
   endtask

   task automatic check_aborted(input string name);
      n_checks++;
      if ({o_busy, o_count, o_out_valid, o_in_ready} !== {1'b0, CW'(0), 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL %s: got busy=%0b count=%0d valid=%0b in_ready=%0b, expected 0/0/0/0", name,
                  o_busy, o_count, o_out_valid, o_in_ready);
      end
      reset = 1'b0;
      #1;
      n_checks++;
      if (o_in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s release: got in_ready=%0b, expected 1", name, o_in_ready);
      end
      m_q.delete();
   endtask

   task automatic test_reset_abort();
      int w;
      sel = 1'b0;
      for (int i = 0; i < 4; i++) push(8'($urandom), 8'(i));
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      check_aborted("abort_sort");
      tick();
      for (int i = 0; i < 3; i++) push(8'($urandom), 8'(i));
      start = 1'b1;
      tick();
      start = 1'b0;
      w = 0;
      while (!o_out_valid && w < 50) begin
         tick();
         w++;
      end
      n_checks++;
      if (o_out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_drain wait: got out_valid=%0b, expected 1", o_out_valid);
      end
      reset = 1'b1;
      tick();
      check_aborted("abort_drain");
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_signed();
      test_stability();
      test_overflow();
      test_small_counts();
      test_random();
      test_reset_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
